// File: rtl/loader_pkg.sv
// Shared types and constants for the UART program loader.
// The optional inter-byte timeout is enabled with LOADER_TIMEOUT_EN.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GET_COUNT,
        GET_BYTES,
        WRITE,
        DONE,
        ERROR
    } state_t;

    localparam int BYTES_PER_WORD = 4;

    // Wide enough for the default TIMEOUT_CYCLES of 100000.
    localparam int TIMEOUT_W = 17;

endpackage

// File: rtl/word_assembler.sv
// Collects received bytes LSB-first into one instruction word.
// The word_valid pulse is combinational with the byte that completes it.
module word_assembler
    import loader_pkg::*;
#(
    parameter int SIZE = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            enable,
    input  logic            strobe,
    input  logic [7:0]      data,
    output logic [SIZE-1:0] word,
    output logic            word_valid
);

    localparam logic [1:0] LAST = 2'(BYTES_PER_WORD - 1);

    logic [1:0]      byte_cnt;
    logic [SIZE-1:0] shift;
    logic            accept;

    assign accept     = enable & strobe;
    assign word       = {data, shift[SIZE-1:8]};
    assign word_valid = accept && (byte_cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            byte_cnt <= '0;
            shift    <= '0;
        end else if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            shift    <= word;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Loads a count-prefixed byte stream into instruction memory.
// Optional inter-byte timeout is enabled with LOADER_TIMEOUT_EN.
module program_loader
    import loader_pkg::*;
#(
    parameter int SIZE           = 32,
    parameter int MEM_SIZE       = 64,
    parameter int ADDR_WIDTH     = $clog2(MEM_SIZE),
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_done,
    output logic                  o_inst_write_enable,
    output logic [ADDR_WIDTH-1:0] o_write_addr,
    output logic [SIZE-1:0]       o_write_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error,
    output logic [ADDR_WIDTH:0]   o_instr_count
);

    localparam int CW = ADDR_WIDTH + 1;

    state_t          state;
    logic [CW-1:0]   word_cnt;
    logic [CW-1:0]   next_cnt;
    logic [31:0]     rx_n;
    logic [SIZE-1:0] word;
    logic            word_valid;
    logic            asm_en;
    logic            asm_clear;
    logic            timed_out;

    assign next_cnt  = word_cnt + 1'b1;
    assign rx_n      = {24'd0, i_rx_data};
    // A byte arriving during WRITE is taken straight into the assembler.
    assign asm_en    = (state == GET_BYTES) || (state == WRITE);
    assign asm_clear = (state == IDLE) && i_start;

    word_assembler #(
        .SIZE(SIZE)
    ) u_asm (
        .clk       (i_clk),
        .rst       (i_rst),
        .clear     (asm_clear),
        .enable    (asm_en),
        .strobe    (i_rx_done),
        .data      (i_rx_data),
        .word      (word),
        .word_valid(word_valid)
    );

`ifdef LOADER_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] to_cnt;

    assign timed_out = !i_rx_done &&
        (to_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst || i_rx_done || i_start) begin
            to_cnt <= '0;
        end else if (state == GET_COUNT || state == GET_BYTES) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state               <= IDLE;
            word_cnt            <= '0;
            o_inst_write_enable <= 1'b0;
            o_write_addr        <= '0;
            o_write_data        <= '0;
            o_busy              <= 1'b0;
            o_done              <= 1'b0;
            o_error             <= 1'b0;
            o_instr_count       <= '0;
        end else begin
            o_inst_write_enable <= 1'b0;
            o_done              <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (i_start) begin
                        state    <= GET_COUNT;
                        word_cnt <= '0;
                        o_error  <= 1'b0;
                        o_busy   <= 1'b1;
                    end
                end
                GET_COUNT: begin
                    if (i_rx_done) begin
                        o_instr_count <= CW'(i_rx_data);
                        if (rx_n != 0 && rx_n <= 32'(MEM_SIZE)) begin
                            state <= GET_BYTES;
                        end else begin
                            state   <= ERROR;
                            o_error <= 1'b1;
                            o_busy  <= 1'b0;
                        end
                    end else if (timed_out) begin
                        state   <= ERROR;
                        o_error <= 1'b1;
                        o_busy  <= 1'b0;
                    end
                end
                GET_BYTES: begin
                    if (word_valid) begin
                        state               <= WRITE;
                        o_inst_write_enable <= 1'b1;
                        o_write_addr        <= word_cnt[ADDR_WIDTH-1:0];
                        o_write_data        <= word;
                    end else if (timed_out) begin
                        state   <= ERROR;
                        o_error <= 1'b1;
                        o_busy  <= 1'b0;
                    end
                end
                WRITE: begin
                    word_cnt <= next_cnt;
                    if (next_cnt == o_instr_count) begin
                        state  <= DONE;
                        o_done <= 1'b1;
                        o_busy <= 1'b0;
                    end else begin
                        state <= GET_BYTES;
                    end
                end
                DONE: state <= IDLE;
                ERROR: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader.
module tb_program_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       we;
    logic [5:0] addr;
    logic [31:0] data;
    logic       busy;
    logic       done;
    logic       error;
    logic [6:0] count;

    int errors = 0;
    int checks = 0;

    logic [5:0]  log_addr[$];
    logic [31:0] log_data[$];
    int          done_cnt = 0;

    always #5 clk = ~clk;

    program_loader #(
        .SIZE          (32),
        .MEM_SIZE      (64),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_start            (start),
        .i_rx_data          (rx_data),
        .i_rx_done          (rx_done),
        .o_inst_write_enable(we),
        .o_write_addr       (addr),
        .o_write_data       (data),
        .o_busy             (busy),
        .o_done             (done),
        .o_error            (error),
        .o_instr_count      (count)
    );

    always @(posedge clk) begin
        if (we) begin
            log_addr.push_back(addr);
            log_data.push_back(data);
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        done_cnt = 0;
    endtask

    logic [7:0] w;
    int         bad;
    int         d0;

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        rx_data = 8'h00;
        rx_done = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_we", we, 0);
        chk("rst_addr", addr, 0);
        chk("rst_data", data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", error, 0);
        chk("rst_count", count, 0);

        // Two-word load
        clear_log();
        pulse_start();
        chk("s1_busy", busy, 1);
        send_byte(8'h02);
        chk("s1_count", count, 2);
        send_byte(8'h78);
        send_byte(8'h56);
        send_byte(8'h34);
        send_byte(8'h12);
        chk("s1_lat_we", we, 1);
        chk("s1_lat_addr", addr, 0);
        chk("s1_lat_data", data, 32'h12345678);
        @(negedge clk);
        chk("s1_we_low", we, 0);
        chk("s1_data_hold", data, 32'h12345678);
        send_byte(8'hEF);
        send_byte(8'hBE);
        send_byte(8'hAD);
        send_byte(8'hDE);
        chk("s1_busy_write", busy, 1);
        repeat (3) @(negedge clk);
        chk("s1_nwr", log_addr.size(), 2);
        if (log_addr.size() == 2) begin
            chk("s1_a0", log_addr[0], 0);
            chk("s1_d0", log_data[0], 32'h12345678);
            chk("s1_a1", log_addr[1], 1);
            chk("s1_d1", log_data[1], 32'hDEADBEEF);
        end
        chk("s1_done", done_cnt, 1);
        chk("s1_busy_end", busy, 0);
        chk("s1_err", error, 0);

        // Bad counts
        clear_log();
        pulse_start();
        send_byte(8'h00);
        chk("n0_err", error, 1);
        chk("n0_busy", busy, 0);
        repeat (3) @(negedge clk);
        chk("n0_sticky", error, 1);
        pulse_start();
        send_byte(8'd65);
        chk("n65_err", error, 1);
        repeat (2) @(negedge clk);
        chk("bad_nwr", log_addr.size(), 0);
        pulse_start();
        chk("clr_err", error, 0);
        send_byte(8'h01);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        repeat (3) @(negedge clk);
        chk("clr_nwr", log_addr.size(), 1);
        if (log_addr.size() == 1) begin
            chk("clr_d0", log_data[0], 32'h44332211);
        end
        chk("clr_err_end", error, 0);

        // Reset mid-word
        clear_log();
        pulse_start();
        send_byte(8'h01);
        send_byte(8'hA1);
        send_byte(8'hA2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mr_busy", busy, 0);
        chk("mr_data", data, 0);
        chk("mr_addr", addr, 0);
        chk("mr_count", count, 0);
        send_byte(8'hA3);
        send_byte(8'hA4);
        repeat (3) @(negedge clk);
        chk("mr_nwr", log_addr.size(), 0);
        pulse_start();
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        send_byte(8'hDD);
        repeat (3) @(negedge clk);
        chk("mr2_nwr", log_addr.size(), 1);
        if (log_addr.size() == 1) begin
            chk("mr2_a0", log_addr[0], 0);
            chk("mr2_d0", log_data[0], 32'hDDCCBBAA);
        end

        // Back-to-back bytes
        clear_log();
        pulse_start();
        send_byte(8'h03);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            rx_data = 8'(i);
            rx_done = 1'b1;
        end
        @(negedge clk);
        rx_done = 1'b0;
        repeat (4) @(negedge clk);
        chk("b2b_nwr", log_addr.size(), 3);
        if (log_addr.size() == 3) begin
            chk("b2b_a0", log_addr[0], 0);
            chk("b2b_d0", log_data[0], 32'h04030201);
            chk("b2b_a1", log_addr[1], 1);
            chk("b2b_d1", log_data[1], 32'h08070605);
            chk("b2b_a2", log_addr[2], 2);
            chk("b2b_d2", log_data[2], 32'h0C0B0A09);
        end
        chk("b2b_done", done_cnt, 1);

        // Stall mid-word
        clear_log();
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h10);
        send_byte(8'h20);
        repeat (51) @(negedge clk);
`ifdef LOADER_TIMEOUT_EN
        chk("to_err", error, 1);
        chk("to_busy", busy, 0);
`else
        chk("to_err", error, 0);
        chk("to_busy", busy, 1);
`endif
        chk("to_nwr", log_addr.size(), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Full memory
        clear_log();
        pulse_start();
        send_byte(8'd64);
        for (int k = 0; k < 64; k++) begin
            w = 8'(k);
            send_byte(w);
            send_byte(~w);
            send_byte(8'h5A);
            send_byte(8'hA5);
        end
        repeat (3) @(negedge clk);
        chk("full_nwr", log_addr.size(), 64);
        if (log_addr.size() == 64) begin
            bad = 0;
            for (int k = 0; k < 64; k++) begin
                w  = 8'(k);
                d0 = 0;
                if (log_addr[k] != 6'(k)) d0 = 1;
                if (log_data[k] != {8'hA5, 8'h5A, ~w, w}) d0 = 1;
                bad += d0;
            end
            chk("full_seq", bad, 0);
            chk("full_a63", log_addr[63], 63);
            chk("full_d63", log_data[63], 32'hA55AC03F);
        end
        chk("full_done", done_cnt, 1);
        chk("full_busy", busy, 0);
        chk("full_err", error, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
